fpu_result_to_fixed: RTL
========================

Name: fpu_result_to_fixed

Overview:
- Downstream consumer of the FPU result bus.
- Takes one 32-bit custom float per transaction: sign[31], exponent[30:25] with bias 31, mantissa[24:0] with a hidden 1. Also takes the 4-bit FPU status.
- Converts the value iteratively (one shift per cycle) to a signed 32-bit fixed-point word with FRAC_BITS fractional bits.
- Feeds the result to fixed-point logic or a register bank over a valid/ready handshake.

Parameters:
- FRAC_BITS, 16, number of fractional bits in out_fixed; legal range 0..30.

Ports:
- clock  in  1  system clock (100 kHz nominal), rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  float result available.
- in_data  in  32  float value {sign, exp[5:0], mant[24:0]}.
- in_status  in  4  FPU flags: [3] overflow, [2] underflow, [1] inexact, [0] zero.
- in_ready  out  1  block can accept a result.
- out_valid  out  1  out_fixed/out_flags are valid.
- out_ready  in  1  consumer accepts the output.
- out_fixed  out  32  signed two's-complement fixed-point result.
- out_flags  out  3  [2] truncated, [1] saturated, [0] zero.

Behaviour:
- Reset (reset=0, async): state=IDLE; in_ready=0 while reset is held, then 1 from the first edge after release; out_valid=0; out_fixed=0; out_flags=0; all internal registers cleared. Reset mid-conversion aborts the conversion with no output.
- IDLE: in_ready=1. Acceptance occurs when in_valid && in_ready at a rising edge. On acceptance:
  - latch sign s, exponent e, sig={1,mant} (26 bits), and in_status;
  - compute k = e - (56 - FRAC_BITS);
  - go to CLASSIFY.
- CLASSIFY (1 cycle, in_ready=0):
  - e==0 or in_status[0]: result 0, flags zero=1.
  - e==63, or in_status[3], or k > 5: saturate to 0x7FFFFFFF (s=0) or 0x80000000 (s=1); saturated=1.
  - in_status[2], or k <= -26: result 0; zero=1, truncated=1.
  - Any of the three cases above goes directly to PACK.
  - Otherwise: load a 26-bit shift register with sig, set count=|k|, clear sticky, go to SHIFT. If count==0, go to PACK.
- SHIFT (|k| cycles, 1..25):
  - k>0: shift left by 1 per cycle (magnitude ≤ 31 bits is guaranteed by k ≤ 5).
  - k<0: shift right by 1 per cycle; OR each bit shifted out into sticky.
  - count decrements each cycle; leave for PACK when count reaches 1 on the shifting edge.
- PACK (1 cycle):
  - out_fixed = s ? -mag : mag (mag zero-extended to 32 bits; truncation toward zero).
  - out_flags = {sticky | in_status[1], saturated, out_fixed==0}.
  - Set out_valid=1 and go to HOLD.
- HOLD: out_valid=1; out_fixed and out_flags stable until out_valid && out_ready at a rising edge. Then out_valid=0, return to IDLE; in_ready=1 from the following cycle.
- Latency from the acceptance edge to out_valid high:
  - 2 edges for special and shortcut cases, and for k=0;
  - |k|+2 edges otherwise.
- Throughput: one conversion in flight. No new acceptance until HOLD completes. in_valid is ignored while in_ready=0.
- Upstream must hold in_data stable only during the acceptance cycle; the block latches everything.
- -0 input (s=1, e=0) yields out_fixed=0, not 0x80000000.

Test Plan (FRAC_BITS=16):
- Reset with reset=0 mid-SHIFT while converting 0x3E000000 -> out_valid=0 and out_fixed=0 immediately; after release, 0x3E000000 (1.0), out_ready=1 -> out_fixed=0x00010000, flags=000, out_valid 11 edges after acceptance.
- 0xBF000000 (-1.5) -> out_fixed=0xFFFE8000, flags=000. Then 0x40400000 (2.25) -> 0x00024000, flags=000, latency 10.
- 0x64000000 (e=50, +2^19), and 0xE4000000 -> 0x7FFFFFFF, flags=010, and 0x80000000, flags=010, both with latency 2. Also in_status=4'b1000 with 0x3E000000 -> 0x7FFFFFFF, flags=010.
- 0x00000000 -> 0x00000000, flags=001, latency 2. 0x14000000 (e=10) -> 0x00000000, flags=101. Mantissa LSB set on 1.0 (0x3E000001) -> 0x00010000, flags=100.
- Backpressure: out_ready=0 for 5 cycles after out_valid -> out_fixed and out_flags held; in_ready=0; a second in_valid is not accepted. out_ready=1 -> one transfer, then in_ready=1 and the second value is accepted next edge.
- Back-to-back: in_valid held high with 3 values and out_ready=1 -> exactly 3 outputs, in order, no drops or duplicates.

Source files
------------

// File: rtl/fpu_result_to_fixed.sv
// rtl/fpu_result_to_fixed.sv - iterative custom-float to signed fixed-point converter
module fpu_result_to_fixed #(
  parameter int FRAC_BITS = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [31:0] in_data,
  input  logic [3:0]  in_status,
  output logic        in_ready,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_fixed,
  output logic [2:0]  out_flags
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLASSIFY,
    S_SHIFT,
    S_PACK,
    S_HOLD
  } state_t;

  // value = sig * 2^(e-56); scaled by 2^FRAC_BITS the shift amount is k
  localparam logic signed [7:0] K_OFFSET = 8'(56 - FRAC_BITS);

  state_t            state_q;
  logic              sign_q;
  logic [5:0]        exp_q;
  logic [3:0]        status_q;
  logic signed [7:0] k_q;
  logic [31:0]       mag_q;
  logic [4:0]        count_q;
  logic              left_q;
  logic              sticky_q;
  logic              sat_q;
  logic              in_ready_q;
  logic              out_valid_q;
  logic [31:0]       out_fixed_q;
  logic [2:0]        out_flags_q;

  logic signed [7:0] k_d;
  logic [4:0]        k_abs;
  logic [31:0]       fixed_d;
  logic [2:0]        flags_d;

  assign k_d   = $signed({2'b00, in_data[30:25]}) - K_OFFSET;
  // only consulted on the shifting path, where -26 < k <= 5
  assign k_abs = 5'(k_q[7] ? -k_q : k_q);

  // Final signed result and flags, captured in PACK
  always_comb begin
    fixed_d = 32'd0;
    if (sat_q) begin
      fixed_d = sign_q ? 32'h8000_0000 : 32'h7FFF_FFFF;
    end else begin
      // -0 naturally yields 0 here since mag is 0
      fixed_d = sign_q ? (32'd0 - mag_q) : mag_q;
    end
    flags_d = {sticky_q | status_q[1], sat_q, (fixed_d == 32'd0)};
  end

  // Conversion FSM: accept, classify, shift one bit per cycle, pack, hold
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      sign_q      <= 1'b0;
      exp_q       <= 6'd0;
      status_q    <= 4'd0;
      k_q         <= 8'sd0;
      mag_q       <= 32'd0;
      count_q     <= 5'd0;
      left_q      <= 1'b0;
      sticky_q    <= 1'b0;
      sat_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_fixed_q <= 32'd0;
      out_flags_q <= 3'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_ready_q && in_valid) begin
            sign_q     <= in_data[31];
            exp_q      <= in_data[30:25];
            mag_q      <= {6'd0, 1'b1, in_data[24:0]};
            status_q   <= in_status;
            k_q        <= k_d;
            in_ready_q <= 1'b0;
            state_q    <= S_CLASSIFY;
          end else begin
            in_ready_q <= 1'b1;
          end
        end
        S_CLASSIFY: begin
          sticky_q <= 1'b0;
          sat_q    <= 1'b0;
          count_q  <= k_abs;
          left_q   <= ~k_q[7];
          if (exp_q == 6'd0 || status_q[0]) begin
            mag_q   <= 32'd0;
            state_q <= S_PACK;
          end else if (exp_q == 6'h3F || status_q[3] || k_q > 8'sd5) begin
            mag_q   <= 32'd0;
            sat_q   <= 1'b1;
            state_q <= S_PACK;
          end else if (status_q[2] || k_q <= -8'sd26) begin
            mag_q    <= 32'd0;
            sticky_q <= 1'b1;
            state_q  <= S_PACK;
          end else if (k_q == 8'sd0) begin
            state_q <= S_PACK;
          end else begin
            state_q <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (left_q) begin
            mag_q <= {mag_q[30:0], 1'b0};
          end else begin
            mag_q    <= {1'b0, mag_q[31:1]};
            sticky_q <= sticky_q | mag_q[0];
          end
          count_q <= count_q - 5'd1;
          if (count_q == 5'd1) begin
            state_q <= S_PACK;
          end
        end
        S_PACK: begin
          out_fixed_q <= fixed_d;
          out_flags_q <= flags_d;
          out_valid_q <= 1'b1;
          state_q     <= S_HOLD;
        end
        S_HOLD: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_fixed = out_fixed_q;
  assign out_flags = out_flags_q;

endmodule
